// File: rtl/echo_pkg.sv
// Shared types and saturation helper for the audio-FX sample path.
// Later FX stages reuse sample_t and sat16 so clipping behaves the same everywhere.
package echo_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  typedef enum logic [1:0] {IDLE, MULT, ADD, HOLD} echo_state_t;

  // A 17-bit sum overflowed exactly when its top two bits disagree.
  function automatic sample_t sat16(input logic signed [SAMPLE_W:0] sum);
    if (sum[SAMPLE_W] == sum[SAMPLE_W-1]) return sum[SAMPLE_W-1:0];
    else if (sum[SAMPLE_W])               return SAMPLE_MIN;
    else                                  return SAMPLE_MAX;
  endfunction

endpackage

// File: rtl/sat_scale_add.sv
// Combinational echo datapath: gain-scale the delayed sample, and add/saturate
// a previously scaled value onto the dry sample. The two halves are split by a register in echo_mix.
module sat_scale_add
  import echo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 8
) (
  input  logic signed [DATA_W-1:0] i_dly,
  input  logic        [GAIN_W-1:0] i_gain,
  input  logic                     i_bypass,
  output logic signed [DATA_W-1:0] o_scaled,
  input  logic signed [DATA_W-1:0] i_dry,
  input  logic signed [DATA_W-1:0] i_scaled,
  output logic signed [DATA_W-1:0] o_sum,
  output logic                     o_clip
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [DATA_W:0]   w_sum;

  // Gain is an unsigned fraction, so it gets a zero sign bit before the signed multiply.
  assign w_prod   = PROD_W'(i_dly) * PROD_W'($signed({1'b0, i_gain}));
  assign o_scaled = i_bypass ? '0 : DATA_W'(w_prod >>> GAIN_W);

  assign w_sum  = (DATA_W+1)'(i_dry) + (DATA_W+1)'(i_scaled);
  assign o_clip = w_sum[DATA_W] ^ w_sum[DATA_W-1];

  generate
    if (DATA_W == SAMPLE_W) begin : g_sat16
      assign o_sum = sat16(w_sum);
    end else begin : g_sat_generic
      assign o_sum = o_clip ? {w_sum[DATA_W], {(DATA_W-1){~w_sum[DATA_W]}}}
                            : w_sum[DATA_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/echo_mix.sv
// Echo mixer: pairs a dry sample with its delayed copy, scales and sums them with
// saturation, and offers the result downstream on a valid/ready handshake.
module echo_mix
  import echo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 8,
  parameter int CLIP_W = 16
) (
  input  logic                     clk50,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] dry_data,
  input  logic                     dry_channel,
  input  logic                     dry_valid,
  output logic                     dry_ready,
  input  logic signed [DATA_W-1:0] dly_data,
  input  logic                     dly_valid,
  output logic                     dly_ready,
  input  logic        [GAIN_W-1:0] gain,
  input  logic                     bypass,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_channel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [CLIP_W-1:0] clip_count
);

  echo_state_t r_state, w_state_nx;

  logic signed [DATA_W-1:0] r_dry, r_dly, r_scaled, r_out_data;
  logic        [GAIN_W-1:0] r_gain;
  logic        [CLIP_W-1:0] r_clip;
  logic r_dry_ch, r_bypass, r_dry_got, r_dly_got;
  logic r_out_ch, r_out_valid, r_dry_ready, r_dly_ready;

  logic w_dry_hs, w_dly_hs, w_dry_got_nx, w_dly_got_nx;
  logic w_dry_ready_nx, w_dly_ready_nx;
  logic w_launch, w_ld_scaled, w_ld_out, w_done, w_clip;
  logic signed [DATA_W-1:0] w_scaled, w_sum;

  // Ready registers are only ever high in IDLE, so a handshake implies IDLE.
  assign w_dry_hs = dry_valid & r_dry_ready;
  assign w_dly_hs = dly_valid & r_dly_ready;

  // Delayed samples taken while bypassed are drained, not kept.
  assign w_dry_got_nx = w_done ? 1'b0 : (r_dry_got | w_dry_hs);
  assign w_dly_got_nx = w_done ? 1'b0 : (r_dly_got | (w_dly_hs & ~bypass));

  assign w_dry_ready_nx = (w_state_nx == IDLE) & ~w_dry_got_nx;
  assign w_dly_ready_nx = (w_state_nx == IDLE) & (~w_dly_got_nx | bypass);

  always_ff @(posedge clk50) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_dry_got_nx && (w_dly_got_nx || bypass)) w_state_nx = MULT;
      MULT:    w_state_nx = ADD;
      ADD:     w_state_nx = HOLD;
      HOLD:    if (r_out_valid && out_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    w_launch    = 1'b0;
    w_ld_scaled = 1'b0;
    w_ld_out    = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE:    w_launch    = (w_state_nx == MULT);
      MULT:    w_ld_scaled = 1'b1;
      ADD:     w_ld_out    = 1'b1;
      HOLD:    w_done      = r_out_valid & out_ready;
      default: ;
    endcase
  end

  sat_scale_add #(
    .DATA_W (DATA_W),
    .GAIN_W (GAIN_W)
  ) u_sat_scale_add (
    .i_dly    (r_dly),
    .i_gain   (r_gain),
    .i_bypass (r_bypass),
    .o_scaled (w_scaled),
    .i_dry    (r_dry),
    .i_scaled (r_scaled),
    .o_sum    (w_sum),
    .o_clip   (w_clip)
  );

  // NOTE: sequential state uses non-blocking assignments only; the data registers
  // are cleared by reset too, so nothing stale can leak out after a mid-sample reset.
  always_ff @(posedge clk50) begin
    if (rst) begin
      r_dry       <= '0;
      r_dry_ch    <= 1'b0;
      r_dly       <= '0;
      r_gain      <= '0;
      r_bypass    <= 1'b0;
      r_scaled    <= '0;
      r_dry_got   <= 1'b0;
      r_dly_got   <= 1'b0;
      r_dry_ready <= 1'b0;
      r_dly_ready <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= 1'b0;
      r_out_valid <= 1'b0;
      r_clip      <= '0;
    end else begin
      if (w_dry_hs) begin
        r_dry    <= dry_data;
        r_dry_ch <= dry_channel;
      end
      if (w_dly_hs && !bypass) r_dly <= dly_data;
      r_dry_got   <= w_dry_got_nx;
      r_dly_got   <= w_dly_got_nx;
      r_dry_ready <= w_dry_ready_nx;
      r_dly_ready <= w_dly_ready_nx;
      // Gain and bypass are frozen per sample so late changes cannot reach it.
      if (w_launch) begin
        r_gain   <= gain;
        r_bypass <= bypass;
      end
      if (w_ld_scaled) r_scaled <= w_scaled;
      if (w_ld_out) begin
        r_out_data  <= w_sum;
        r_out_ch    <= r_dry_ch;
        r_out_valid <= 1'b1;
        if (w_clip && !(&r_clip)) r_clip <= r_clip + 1'b1;
      end else if (w_done) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign dry_ready   = r_dry_ready;
  assign dly_ready   = r_dly_ready;
  assign out_data    = r_out_data;
  assign out_channel = r_out_ch;
  assign out_valid   = r_out_valid;
  assign clip_count  = r_clip;

endmodule

// File: tb/tb_echo_mix.sv
// Randomised bench for echo_mix: a plain-arithmetic model of the echo mix is
// compared against every output transfer, plus handshake, stall and reset behaviour.
module tb_echo_mix;

  logic               clk50 = 1'b0;
  logic               rst;
  logic signed [15:0] dry_data, dly_data, out_data;
  logic               dry_channel, dry_valid, dry_ready;
  logic               dly_valid, dly_ready;
  logic        [7:0]  gain;
  logic               bypass, out_channel, out_valid, out_ready;
  logic        [15:0] clip_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_clip = 0;

  always #10 clk50 = ~clk50;

  echo_mix #(.DATA_W(16), .GAIN_W(8), .CLIP_W(16)) dut (
    .clk50       (clk50),
    .rst         (rst),
    .dry_data    (dry_data),
    .dry_channel (dry_channel),
    .dry_valid   (dry_valid),
    .dry_ready   (dry_ready),
    .dly_data    (dly_data),
    .dly_valid   (dly_valid),
    .dly_ready   (dly_ready),
    .gain        (gain),
    .bypass      (bypass),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clip_count  (clip_count)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Echo mix from first principles: floor(dly*gain/256) added to dry, clamped to 16 bits.
  function automatic int model_mix(input int d, input int y, input int g,
                                   input bit bp, output bit clip);
    int p, scaled, sum;
    p = y * g;
    scaled = p / 256;
    if (p < 0 && (p % 256) != 0) scaled = scaled - 1;
    if (bp) scaled = 0;
    sum  = d + scaled;
    clip = (sum > 32767) || (sum < -32768);
    if (sum > 32767)  return 32767;
    if (sum < -32768) return -32768;
    return sum;
  endfunction

  function automatic int rand16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  // One complete sample; lead = cycles the delayed sample arrives ahead of dry,
  // stall = cycles out_ready is held low in HOLD, rst_in_hold = reset instead of transfer.
  task automatic run_sample(input string name, input int d, input bit ch, input int y,
                            input int g, input bit bp, input int lead, input int stall,
                            input bit rst_in_hold);
    bit clip, dry_done, dly_done, hs_dry, hs_dly;
    int exp_out, cyc;
    exp_out = model_mix(d, y, g, bp, clip);
    if (clip && exp_clip != 65535) exp_clip++;
    gain      = 8'(g);
    bypass    = bp;
    out_ready = (stall == 0);
    @(negedge clk50);
    check({name, ".dry_ready_idle"}, dry_ready, 1);
    dry_done = 1'b0;
    dly_done = bp;

    if (lead > 0) begin
      dly_valid = 1'b1;
      dly_data  = 16'(y);
      cyc = 0;
      while (!dly_ready && cyc < 20) begin
        @(negedge clk50);
        cyc++;
      end
      @(posedge clk50);
      #1 dly_valid = 1'b0;
      dly_done = 1'b1;
      repeat (lead) @(negedge clk50);
      check({name, ".dly_ready_after_capture"}, dly_ready, 0);
      check({name, ".dry_ready_waiting"}, dry_ready, 1);
    end

    dry_valid   = 1'b1;
    dry_data    = 16'(d);
    dry_channel = ch;
    if (!dly_done || bp) begin
      dly_valid = 1'b1;
      dly_data  = bp ? 16'($urandom) : 16'(y);
    end
    cyc = 0;
    while (!(dry_done && dly_done) && cyc < 20) begin
      hs_dry = dry_valid && dry_ready;
      hs_dly = dly_valid && dly_ready;
      if (bp && cyc == 0) check({name, ".bypass_drain_ready"}, dly_ready, 1);
      @(posedge clk50);
      #1;
      if (hs_dry) begin dry_valid = 1'b0; dry_done = 1'b1; end
      if (hs_dly) begin dly_valid = 1'b0; if (!bp) dly_done = 1'b1; end
      cyc++;
      @(negedge clk50);
    end
    dly_valid = 1'b0;
    dry_valid = 1'b0;
    if (!(dry_done && dly_done)) begin
      check({name, ".handshake_timeout"}, 0, 1);
      return;
    end

    // Now one edge past the completing handshake.
    check({name, ".valid_lat1"}, out_valid, 0);
    check({name, ".dry_ready_busy"}, dry_ready, 0);
    check({name, ".dly_ready_busy"}, dly_ready, 0);
    @(negedge clk50);
    check({name, ".valid_lat2"}, out_valid, 0);
    @(negedge clk50);
    check({name, ".valid_rise"}, out_valid, 1);
    check({name, ".out_data"}, out_data, exp_out);
    check({name, ".out_channel"}, out_channel, ch);
    check({name, ".clip_count"}, clip_count, exp_clip);

    if (rst_in_hold) begin
      rst = 1'b1;
      @(negedge clk50);
      exp_clip = 0;
      check({name, ".rst_valid"}, out_valid, 0);
      check({name, ".rst_clip"}, clip_count, 0);
      check({name, ".rst_data"}, out_data, 0);
      check({name, ".rst_dry_ready"}, dry_ready, 0);
      check({name, ".rst_dly_ready"}, dly_ready, 0);
      @(negedge clk50);
      check({name, ".rst_held_ready"}, dry_ready, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk50);
      check({name, ".post_rst_dry_ready"}, dry_ready, 1);
      check({name, ".post_rst_dly_ready"}, dly_ready, 1);
      return;
    end

    for (int i = 0; i < stall; i++) begin
      @(negedge clk50);
      check({name, ".stall_valid"}, out_valid, 1);
      check({name, ".stall_data"}, out_data, exp_out);
      check({name, ".stall_channel"}, out_channel, ch);
    end
    out_ready = 1'b1;
    @(negedge clk50);
    check({name, ".valid_fall"}, out_valid, 0);
    check({name, ".dry_ready_again"}, dry_ready, 1);
    check({name, ".dly_ready_again"}, dly_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    dry_data = '0; dry_channel = 1'b0; dry_valid = 1'b0;
    dly_data = '0; dly_valid = 1'b0;
    gain = '0; bypass = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk50);
    check("reset.out_valid", out_valid, 0);
    check("reset.out_data", out_data, 0);
    check("reset.out_channel", out_channel, 0);
    check("reset.clip_count", clip_count, 0);
    check("reset.dry_ready", dry_ready, 0);
    check("reset.dly_ready", dly_ready, 0);
    rst = 1'b0;
    @(negedge clk50);
    check("release.dry_ready", dry_ready, 1);
    check("release.dly_ready", dly_ready, 1);

    run_sample("half_gain",   1000,   0, 2000,   128, 0, 0,  0, 0);
    run_sample("clip_pos",    30000,  0, 8000,   255, 0, 0,  0, 0);
    run_sample("clip_neg",   -30000,  1, -8000,  255, 0, 0,  0, 0);
    run_sample("zero_gain",   5,      0, 0,      0,   0, 0,  0, 0);
    run_sample("bypass",     -5,      0, 0,      77,  1, 0,  0, 0);
    run_sample("dly_early",   1234,   1, -4321,  200, 0, 10, 5, 0);
    run_sample("rst_in_hold", 32000,  0, 32000,  255, 0, 0,  1, 1);

    for (int k = 0; k < 60; k++) begin
      bit bp;
      bp = ($urandom_range(0, 7) == 0);
      run_sample("rand", rand16(), 1'($urandom), rand16(), int'($urandom_range(0, 255)),
                 bp, bp ? 0 : int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_mix.md
Name: echo_mix

Overview:
- Downstream consumer of the SDRAM sample-storage stage in the audio-FX path.
- Takes the live (dry) sample and the one-second-delayed sample read back from storage, and scales the delayed sample by a programmable gain.
- Sums the scaled delayed sample with the dry sample, saturates the result and hands it to the codec output stage over a valid/ready handshake.
- Keeps a saturating clip counter for the front-panel/debug display.

Parameters:
DATA_W, 16, sample width (signed two's complement)
GAIN_W, 8, gain width; unsigned fraction, gain/2^GAIN_W (255 → 0.996)
CLIP_W, 16, clip counter width

Ports:
clk50  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
dry_data  in  DATA_W  signed live sample
dry_channel  in  1  channel tag of dry sample (0 = left, 1 = right)
dry_valid  in  1  dry sample valid
dry_ready  out  1  dry sample accepted when dry_valid && dry_ready
dly_data  in  DATA_W  signed delayed sample from storage stage
dly_valid  in  1  delayed sample valid
dly_ready  out  1  delayed sample accepted when dly_valid && dly_ready
gain  in  GAIN_W  echo gain, quasi-static
bypass  in  1  1 = output dry only
out_data  out  DATA_W  signed mixed sample
out_channel  out  1  channel tag carried from dry sample
out_valid  out  1  output valid
out_ready  in  1  downstream ready
clip_count  out  CLIP_W  number of saturated outputs since reset; sticks at all-ones

Behaviour:
- Reset (rst = 1 at a clk50 edge), all registers 0 on the next edge:
  - outputs 0: out_data, out_channel, out_valid, dry_ready, dly_ready, clip_count.
  - FSM → IDLE; captured-data flags cleared.
  - A reset arriving in any state discards any in-flight sample.
- FSM states: IDLE, MULT, ADD, HOLD.
- IDLE, capture rules:
  - dry_ready = ~dry_got; dly_ready = ~dly_got, except dly_ready = 1 while bypass = 1 (delayed stream is drained and discarded).
  - On a dry handshake: register dry_data and dry_channel, set dry_got.
  - On a dly handshake: register dly_data, set dly_got.
  - Both handshakes may occur in the same cycle.
  - Leave IDLE for MULT when dry_got && (dly_got || bypass), including a handshake that completes on the current edge.
  - Gain is registered on that same edge.
- Outside IDLE, dry_ready = dly_ready = 0.
- MULT:
  - prod = dly_reg * {1'b0, gain_reg}, signed, DATA_W+GAIN_W+1 bits.
  - scaled = prod >>> GAIN_W (arithmetic shift, floor toward −inf), registered.
  - If bypass, scaled = 0.
  - → ADD.
- ADD:
  - sum = dry_reg + scaled, computed at DATA_W+1 bits.
  - If sum > 2^(DATA_W−1)−1, out_data = 32767 (DATA_W = 16).
  - If sum < −2^(DATA_W−1), out_data = −32768.
  - Otherwise out_data = sum[DATA_W−1:0].
  - On saturation, clip_count increments unless already all-ones.
  - out_channel = dry channel reg; out_valid ← 1; → HOLD.
- HOLD:
  - out_data and out_channel are stable while out_valid = 1.
  - On out_valid && out_ready: out_valid ← 0, clear dry_got/dly_got, → IDLE.
- Latency: out_valid rises on the 3rd clk50 edge after the edge completing the last required input handshake.
  - With out_ready held high, out_valid is high for exactly one cycle.
  - Minimum sample period 4 cycles; far above the 48 kHz × 2 channel rate.
- Changes to gain or bypass outside IDLE do not affect the sample in flight.
- A channel mismatch between dry and delayed samples is not checked; the out channel follows dry.

Decomposition:
- Shared package echo_pkg:
  - typedef enum logic [1:0] {IDLE, MULT, ADD, HOLD} echo_state_t
  - sample_t (signed [DATA_W-1:0])
  - SAMPLE_MAX / SAMPLE_MIN localparams
  - function sat16(sum) used by this block and later FX stages
- One sub-module, sat_scale_add: purely combinational multiply/shift/add/saturate with a clip flag output.
  - echo_mix keeps the FSM, handshakes and registers.

Test Plan:
- dry = 1000, dly = 2000, gain = 128, bypass = 0, out_ready = 1 → out_data = 2000, out_valid 1 cycle at 3rd edge after handshake, clip_count = 0.
- dry = 30000, dly = 8000, gain = 255 → scaled = 7968, sum = 37968 → out_data = 32767, clip_count = 1.
- dry = −30000, dly = −8000, gain = 255 → scaled = −7969 → out_data = −32768, clip_count = 2; with dly = 0, gain = 0, dry = 5 → out_data = 5, clip_count unchanged.
- bypass = 1, dry = −5, dly_valid = 0 → out_data = −5; with dly_valid pulsed, dly_ready = 1 (delayed sample drained).
- dly arrives 10 cycles before dry, dry_channel = 1, out_ready low 5 cycles in HOLD → dly_ready low after capture; out_data/out_channel = 1 stable while stalled; exactly one output transfer; dry_ready high again the cycle after.
- rst asserted during HOLD with clip_count = 3 → next edge out_valid = 0, clip_count = 0, dry_ready = dly_ready = 0; first edge after rst deasserts, both ready return to 1.
